// File: rtl/lsu_wb_bridge.sv
// LSU-to-Wishbone bridge: accepts one upstream request, replays it on a
// registered downstream master, and returns a single-cycle completion.
// A downstream hang turns into an error completion after TIMEOUT_CYCLES.
module lsu_wb_bridge #(
  parameter int VIRTUAL_ADDR_LEN = 32,  // same value as VIRTUAL_ADDR_LEN in params.vh
  parameter int WB_DATA_LEN      = 32,
  parameter int TIMEOUT_CYCLES   = 256
) (
  input  logic                          clk,
  input  logic                          rstn,   // active-high synchronous reset
  input  logic                          flush,
  input  logic                          s_cyc_i,
  input  logic                          s_stb_i,
  input  logic                          s_we_i,
  input  logic [VIRTUAL_ADDR_LEN-1:0]   s_adr_i,
  input  logic [WB_DATA_LEN-1:0]        s_dat_i,
  input  logic [WB_DATA_LEN/8-1:0]      s_sel_i,
  output logic                          s_ack_o,
  output logic                          s_err_o,
  output logic [WB_DATA_LEN-1:0]        s_dat_o,
  output logic                          m_cyc_o,
  output logic                          m_stb_o,
  output logic                          m_we_o,
  output logic [VIRTUAL_ADDR_LEN-1:0]   m_adr_o,
  output logic [WB_DATA_LEN-1:0]        m_dat_o,
  output logic [WB_DATA_LEN/8-1:0]      m_sel_o,
  input  logic                          m_ack_i,
  input  logic                          m_err_i,
  input  logic [WB_DATA_LEN-1:0]        m_dat_i
);

  localparam int SEL_W = WB_DATA_LEN/8;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;

  state_e                        state_q, state_d;
  logic                          we_q, we_d;
  logic [VIRTUAL_ADDR_LEN-1:0]   adr_q, adr_d;
  logic [WB_DATA_LEN-1:0]        wdat_q, wdat_d;
  logic [SEL_W-1:0]              sel_q, sel_d;
  logic [WB_DATA_LEN-1:0]        rdat_q, rdat_d;
  logic                          err_q, err_d;
  logic                          drop_q, drop_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;

  logic accept, timeout, done;

  assign accept  = s_cyc_i & s_stb_i & ~flush;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign done    = m_err_i | m_ack_i | timeout;

  // State register
  always_ff @(posedge clk) begin
    if (rstn) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state: one request in flight, RESP is always a single cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (done)   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: master driven only in BUSY, completion only in RESP unless dropped
  always_comb begin
    m_cyc_o = (state_q == BUSY);
    m_stb_o = (state_q == BUSY);
    m_we_o  = we_q;
    m_adr_o = adr_q;
    m_dat_o = wdat_q;
    m_sel_o = sel_q;
    s_ack_o = (state_q == RESP) & ~drop_q & ~flush;
    s_err_o = s_ack_o & err_q;
    s_dat_o = s_ack_o ? rdat_q : '0;
  end

  // Datapath next-state: capture request, count wait cycles, latch completion
  always_comb begin
    we_d   = we_q;
    adr_d  = adr_q;
    wdat_d = wdat_q;
    sel_d  = sel_q;
    rdat_d = rdat_q;
    err_d  = err_q;
    drop_d = drop_q;
    cnt_d  = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        drop_d = 1'b0;
        if (accept) begin
          we_d   = s_we_i;
          adr_d  = s_adr_i;
          wdat_d = s_dat_i;
          sel_d  = s_sel_i;
        end
      end
      BUSY: begin
        // A flush cannot abort the bus cycle; it only hides the completion.
        if (flush) drop_d = 1'b1;
        if (m_err_i) begin
          err_d  = 1'b1;
          rdat_d = '0;
        end else if (m_ack_i) begin
          err_d  = 1'b0;
          rdat_d = we_q ? '0 : m_dat_i;
        end else if (timeout) begin
          err_d  = 1'b1;
          rdat_d = '1;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      RESP:    drop_d = 1'b0;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rstn) begin
      we_q   <= 1'b0;
      adr_q  <= '0;
      wdat_q <= '0;
      sel_q  <= '0;
      rdat_q <= '0;
      err_q  <= 1'b0;
      drop_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      we_q   <= we_d;
      adr_q  <= adr_d;
      wdat_q <= wdat_d;
      sel_q  <= sel_d;
      rdat_q <= rdat_d;
      err_q  <= err_d;
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
